// File: rtl/sorter_pkg.sv
// Shared definitions for the sorter datapath and its output serializer:
// default word width, order-check mode and serializer state encoding.
package sorter_pkg;

    localparam int SORTER_W          = 4;
    localparam bit SORTER_SIGNED_CMP = 1'b0;
    localparam logic [1:0] LAST_IDX  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/sorted_serializer_order_check.sv
// Combinational non-decreasing order check over four words; equal neighbours
// are legal, signedness selected by SIGNED_CMP.
module order_check #(
    parameter int W          = 4,
    parameter bit SIGNED_CMP = 1'b0
) (
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    input  logic [W-1:0] in3,
    input  logic [W-1:0] in4,
    output logic         order_err
);

    logic [W-1:0] words [4];
    logic [2:0]   viol;

    assign words[0] = in1;
    assign words[1] = in2;
    assign words[2] = in3;
    assign words[3] = in4;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_pair
            if (SIGNED_CMP) begin : g_signed
                assign viol[gi] = $signed(words[gi]) > $signed(words[gi+1]);
            end else begin : g_unsigned
                assign viol[gi] = words[gi] > words[gi+1];
            end
        end
    endgenerate

    assign order_err = |viol;

endmodule

// File: rtl/sorted_serializer.sv
// Captures four sorted words and drains them one per valid/ready transfer,
// flagging a capture that is not in non-decreasing order.
module sorted_serializer
    import sorter_pkg::*;
#(
    parameter int W          = SORTER_W,
    parameter bit SIGNED_CMP = SORTER_SIGNED_CMP
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    input  logic [W-1:0] in3,
    input  logic [W-1:0] in4,
    output logic         busy,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         order_err,
    output logic         done
);

    state_t       state_q, state_d;
    logic [W-1:0] buf_q [4];
    logic [W-1:0] buf_d [4];
    logic [1:0]   idx_q, idx_d;
    logic         order_err_q, order_err_d;
    logic         cap_err;

    order_check #(.W(W), .SIGNED_CMP(SIGNED_CMP)) u_order_check (
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .in4       (in4),
        .order_err (cap_err)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        order_err_d = order_err_q;
        for (int i = 0; i < 4; i++) buf_d[i] = buf_q[i];

        case (state_q)
            IDLE: begin
                if (load) begin
                    buf_d[0]    = in1;
                    buf_d[1]    = in2;
                    buf_d[2]    = in3;
                    buf_d[3]    = in4;
                    idx_d       = 2'd0;
                    order_err_d = cap_err;
                    state_d     = SEND;
                end
            end
            SEND: begin
                // Index saturates at the last word; the frame ends instead of wrapping.
                if (out_ready) begin
                    if (idx_q == LAST_IDX) state_d = FIN;
                    else                   idx_d   = idx_q + 2'd1;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= 2'd0;
            order_err_q <= 1'b0;
            for (int i = 0; i < 4; i++) buf_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            order_err_q <= order_err_d;
            for (int i = 0; i < 4; i++) buf_q[i] <= buf_d[i];
        end
    end

    assign busy      = (state_q == SEND);
    assign out_valid = (state_q == SEND);
    assign out_data  = out_valid ? buf_q[idx_q] : '0;
    assign out_last  = out_valid && (idx_q == LAST_IDX);
    assign done      = (state_q == FIN);
    assign order_err = order_err_q;

endmodule

// File: tb/tb_sorted_serializer.sv
// Scoreboard bench: stimulus pushes expected words, a negedge monitor pops
// and compares on every transfer and checks stability while stalled.
module tb_sorted_serializer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         load = 1'b0;
    logic         load2 = 1'b0;
    logic [W-1:0] in1 = '0, in2 = '0, in3 = '0, in4 = '0;
    logic         out_ready = 1'b0;
    logic         rdy2 = 1'b1;

    logic         busy, out_valid, out_last, order_err, done;
    logic [W-1:0] out_data;
    logic         busy2, out_valid2, out_last2, order_err2, done2;
    logic [W-1:0] out_data2;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int cyc = 0;

    logic [W:0] sb [$];

    logic         hold_pending = 1'b0;
    logic [W-1:0] hold_data = '0;
    logic         hold_last = 1'b0;

    sorted_serializer #(.W(W), .SIGNED_CMP(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .load(load),
        .in1(in1), .in2(in2), .in3(in3), .in4(in4),
        .busy(busy), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last),
        .order_err(order_err), .done(done)
    );

    sorted_serializer #(.W(W), .SIGNED_CMP(1'b1)) dut_signed (
        .clk(clk), .rst_n(rst_n), .load(load2),
        .in1(in1), .in2(in2), .in3(in3), .in4(in4),
        .busy(busy2), .out_data(out_data2), .out_valid(out_valid2),
        .out_ready(rdy2), .out_last(out_last2),
        .order_err(order_err2), .done(done2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endfunction

    // Monitor: scoreboard pop on each transfer, stability check on each stall.
    always @(negedge clk) begin
        logic [W:0] e;
        if (rst_n && hold_pending) begin
            checks++;
            if (!(out_valid && out_data == hold_data && out_last == hold_last)) begin
                failures++;
                $display("FAIL hold: got v=%0b d=%0d l=%0b expected v=1 d=%0d l=%0b",
                         out_valid, out_data, out_last, hold_data, hold_last);
            end
        end
        hold_pending = rst_n && out_valid && !out_ready;
        hold_data    = out_data;
        hold_last    = out_last;
        if (rst_n && done) done_cnt++;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_xfer: got d=%0d expected no transfer", out_data);
            end else begin
                e = sb.pop_front();
                chk("xfer_data", int'(out_data), int'(e[W-1:0]));
                chk("xfer_last", int'(out_last), int'(e[W]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [W-1:0] a, b, c, d);
        in1 = a; in2 = b; in3 = c; in4 = d;
    endtask

    task automatic push4(input logic [W-1:0] a, b, c, d);
        sb.push_back({1'b0, a});
        sb.push_back({1'b0, b});
        sb.push_back({1'b0, c});
        sb.push_back({1'b1, d});
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s: got no done pulse expected done within 100 cycles", name);
        end
    endtask

    initial begin
        int d0;
        int t0;
        int t1;
        bit seen;
        logic [6:0] pat;

        // Reset
        step(); step();
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_data", int'(out_data), 0);
        chk("rst_last", int'(out_last), 0);
        chk("rst_err", int'(order_err), 0);
        chk("rst_done", int'(done), 0);
        step();
        rst_n = 1'b1;
        step();

        // Basic stream
        out_ready = 1'b1;
        set_in(4'd1, 4'd2, 4'd6, 4'd12);
        push4(4'd1, 4'd2, 4'd6, 4'd12);
        d0 = done_cnt;
        load = 1'b1;
        step();
        load = 1'b0;
        @(negedge clk);
        chk("basic_lat_valid", int'(out_valid), 1);
        chk("basic_busy", int'(busy), 1);
        wait_done("basic_done");
        chk("basic_busy_fin", int'(busy), 0);
        chk("basic_err", int'(order_err), 0);
        chk("basic_sb_empty", sb.size(), 0);
        @(negedge clk);
        chk("basic_done_1cyc", int'(done), 0);
        chk("basic_done_cnt", done_cnt - d0, 1);

        // Signed vs unsigned order check on (-4,1,2,6)
        step();
        set_in(4'd12, 4'd1, 4'd2, 4'd6);
        push4(4'd12, 4'd1, 4'd2, 4'd6);
        load = 1'b1;
        load2 = 1'b1;
        step();
        load = 1'b0;
        load2 = 1'b0;
        @(negedge clk);
        chk("signed_err", int'(order_err2), 0);
        chk("signed_first", int'(out_data2), 12);
        chk("unsigned_err", int'(order_err), 1);
        wait_done("unsigned_done");
        chk("unsigned_err_hold", int'(order_err), 1);

        // Backpressure with duplicate words
        step();
        set_in(4'd3, 4'd3, 4'd5, 4'd9);
        push4(4'd3, 4'd3, 4'd5, 4'd9);
        load = 1'b1;
        out_ready = 1'b0;
        step();
        load = 1'b0;
        pat = 7'b1011001;
        for (int i = 0; i < 7; i++) begin
            out_ready = pat[i];
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_done_after_4", int'(done), 1);
        chk("bp_err", int'(order_err), 0);
        chk("bp_sb_empty", sb.size(), 0);

        // Load while busy is ignored
        step();
        set_in(4'd0, 4'd1, 4'd2, 4'd3);
        push4(4'd0, 4'd1, 4'd2, 4'd3);
        load = 1'b1;
        step();
        load = 1'b0;
        step();
        set_in(4'd9, 4'd8, 4'd7, 4'd6);
        load = 1'b1;
        step();
        load = 1'b0;
        wait_done("midload_done");
        chk("midload_err", int'(order_err), 0);
        step(); step();
        @(negedge clk);
        chk("midload_no_refill", int'(out_valid), 0);
        chk("midload_sb_empty", sb.size(), 0);

        // Reset mid-stream
        step();
        set_in(4'd10, 4'd11, 4'd12, 4'd13);
        push4(4'd10, 4'd11, 4'd12, 4'd13);
        load = 1'b1;
        step();
        load = 1'b0;
        step(); step();
        rst_n = 1'b0;
        d0 = done_cnt;
        step();
        @(negedge clk);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_valid", int'(out_valid), 0);
        chk("mrst_data", int'(out_data), 0);
        chk("mrst_last", int'(out_last), 0);
        chk("mrst_done", int'(done), 0);
        sb.delete();
        step();
        rst_n = 1'b1;
        step(); step();
        chk("mrst_no_done", done_cnt - d0, 0);
        set_in(4'd4, 4'd5, 4'd6, 4'd7);
        push4(4'd4, 4'd5, 4'd6, 4'd7);
        load = 1'b1;
        step();
        load = 1'b0;
        @(negedge clk);
        chk("mrst_restart_first", int'(out_data), 4);
        wait_done("mrst_restart_done");
        chk("mrst_sb_empty", sb.size(), 0);

        // Back-to-back frames with load held high
        step();
        set_in(4'd2, 4'd4, 4'd6, 4'd8);
        push4(4'd2, 4'd4, 4'd6, 4'd8);
        push4(4'd2, 4'd4, 4'd6, 4'd8);
        load = 1'b1;
        step();
        @(negedge clk);
        chk("b2b_first_valid", int'(out_valid), 1);
        t0 = cyc;
        wait_done("b2b_done1");
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        t1 = cyc;
        load = 1'b0;
        chk("b2b_second_seen", int'(seen), 1);
        chk("b2b_period", t1 - t0, 6);
        wait_done("b2b_done2");
        chk("b2b_sb_empty", sb.size(), 0);

        step(); step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sorted_serializer.md
Name: sorted_serializer

Overview:
- Output-side companion to top_sorter. Captures the four sorted words o1..o4 in one cycle and streams them out one word per transfer over a valid/ready interface, smallest-index word first.
- Checks that the captured vector is in non-decreasing order and flags any violation.
- Sits between top_sorter and downstream serial consumers (UART/logging path). Lets the sorter output be checked and drained without a wide bus.

Parameters:
- W, 4, word width; must match the top_sorter data width.
- SIGNED_CMP, 0, 0 = unsigned order check; 1 = two's-complement order check (e.g. 4'b1100 treated as -4).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset, sampled on rising clk edge
- load  input  1  capture request; accepted only in IDLE
- in1  input  W  sorted word 0 (from top_sorter o1)
- in2  input  W  sorted word 1 (o2)
- in3  input  W  sorted word 2 (o3)
- in4  input  W  sorted word 3 (o4)
- busy  output  1  high from accepted load until the last word transfers
- out_data  output  W  current word
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts when high
- out_last  output  1  high with the 4th word
- order_err  output  1  captured vector was not non-decreasing
- done  output  1  one-cycle pulse after the last transfer

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; all outputs (busy, out_data, out_valid, out_last, order_err, done) = 0; index=0; buffer cleared. Reset overrides every other input, including mid-stream; any partial stream is abandoned with no done pulse.
- States: IDLE, SEND, FIN.
- IDLE:
  - load=1 → capture in1..in4 into buf[0..3], index=0, compute order_err, go to SEND.
  - busy=1 and out_valid=1 from the next cycle; out_data=buf[0].
  - Latency from load to first out_valid: 1 cycle.
- order_err:
  - Set at capture if buf[k] > buf[k+1] for any k in 0..2, using SIGNED_CMP semantics.
  - Equal adjacent words are legal.
  - Holds until the next accepted load or reset. It does not block streaming.
- SEND:
  - out_data=buf[index], out_valid=1, out_last=(index==3).
  - Transfer = out_valid & out_ready at a clk edge.
  - On transfer with index<3: index+1.
  - On transfer with index==3: out_valid, out_last and busy drop next cycle; go to FIN.
  - No transfer: out_data, out_valid and out_last hold stable (AXI-style: valid never drops without a transfer).
- FIN: done=1 for exactly one cycle, then IDLE. load is ignored in FIN.
- load while in SEND or FIN is ignored; the buffer is not overwritten.
- Back-to-back loads: earliest next accept is the cycle after FIN, giving a minimum 6-cycle period with out_ready tied high.
- out_ready held low indefinitely: the block stalls in SEND with no timeout.
- Width: index is 2 bits, no wrap beyond 3. Comparisons use $signed only when SIGNED_CMP=1.

Decomposition:
- Shared package sorter_pkg: W default, SIGNED_CMP default, state encoding constants (IDLE=2'd0, SEND=2'd1, FIN=2'd2). top_sorter reuses W from the same package.
- One natural sub-module: order_check (combinational, 4×W in, SIGNED_CMP param, order_err out), reusable by the sorter bench as a self-check.
- FSM, buffer and handshake stay in sorted_serializer.

Test Plan:
- Basic stream: load with in=(1,2,6,12), out_ready=1 → out_data 1,2,6,12 on consecutive cycles; out_last only with 12; done pulse one cycle after; order_err=0.
- Signed check: SIGNED_CMP=1, in=(12,1,2,6) i.e. (-4,1,2,6) → order_err=0. Same vector with SIGNED_CMP=0 → order_err=1, stream still emits 12,1,2,6.
- Backpressure: in=(3,3,5,9), out_ready toggles 1,0,0,1,1,0,1 → each word held stable while ready=0; exactly 4 transfers; duplicate 3s allowed, order_err=0.
- Load during busy: load=1 with (9,8,7,6) mid-stream of (0,1,2,3) → stream remains 0,1,2,3; order_err stays 0; buffer unchanged.
- Reset mid-stream: rst_n=0 after the 2nd transfer → next cycle all outputs 0, no done pulse. A new load of (4,5,6,7) then streams correctly from 4.
- Back-to-back: load held high, out_ready=1 → second capture occurs the cycle after done; first out_valid of the second frame appears 6 cycles after the first frame's first out_valid.
